// File: rtl/mux_41.sv
`default_nettype none
// ============================================================================
//  Module   : mux_41
//  Purpose  : Four-input selector with a combinational output plus a
//             registered copy of that output and a select-change flag.
//
//  Ports
//    s0, s1      select LSB / MSB, sel = {s1,s0}
//    i0..i3      WIDTH-bit data inputs, chosen when sel = 0..3
//    y           combinational selected data (no clock or reset involvement)
//    clk         clock for the registered outputs only
//    rst         synchronous active-high reset, registered outputs only
//    y_q         y registered on the rising edge of clk
//    sel_chg     one-cycle pulse when the registered select changes
//    sel_cnt     (only with MUX_41_SEL_STATS_EN) four 8-bit saturating
//                per-select occupancy counters, cnt3 in [31:24] .. cnt0 [7:0]
//
//  Optional feature macro : MUX_41_SEL_STATS_EN
//
//  Revision : 1.0  initial release
// ============================================================================
module mux_41 #(
    parameter int WIDTH = 1
) (
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_chg
`ifdef MUX_41_SEL_STATS_EN
    ,
    output logic [31:0]      sel_cnt
`endif
);

    logic [1:0]       w_sel;
    logic [1:0]       r_sel_q;
    logic             r_prev_valid;
    logic [WIDTH-1:0] r_y_q;
    logic             r_sel_chg;

    assign w_sel = {s1, s0};

    // Unknown select bits fall into the default arm so y goes X in
    // simulation instead of silently picking one of the inputs.
    always_comb begin
        case (w_sel)
            2'b00:   y = i0;
            2'b01:   y = i1;
            2'b10:   y = i2;
            2'b11:   y = i3;
            default: y = {WIDTH{1'bx}};
        endcase
    end

    // r_prev_valid marks that r_sel_q holds a select actually sampled after
    // reset; until then a comparison against the reset value of r_sel_q
    // would report a spurious change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q        <= '0;
            r_sel_q      <= 2'b00;
            r_sel_chg    <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_y_q        <= y;
            r_sel_q      <= w_sel;
            r_sel_chg    <= r_prev_valid && (w_sel != r_sel_q);
            r_prev_valid <= 1'b1;
        end
    end

    assign y_q     = r_y_q;
    assign sel_chg = r_sel_chg;

`ifdef MUX_41_SEL_STATS_EN
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        localparam logic [1:0] c_IDX = 2'(k);
        logic [7:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= 8'h00;
            end else if ((w_sel == c_IDX) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 8'h01;
            end
        end

        assign sel_cnt[8*k +: 8] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_41.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_41
//  Purpose  : Self-checking bench for mux_41. A WIDTH=1 instance takes the
//             directed vectors and corner sequences; a WIDTH=8 instance takes
//             random traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_41;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // WIDTH=1 instance
    logic a_s0 = 0, a_s1 = 0, a_rst = 0;
    logic a_i0 = 0, a_i1 = 0, a_i2 = 0, a_i3 = 0;
    logic a_y, a_y_q, a_sel_chg;
    // WIDTH=8 instance
    logic       b_s0 = 0, b_s1 = 0, b_rst = 0;
    logic [7:0] b_i0 = 0, b_i1 = 0, b_i2 = 0, b_i3 = 0;
    logic [7:0] b_y, b_y_q;
    logic       b_sel_chg;
`ifdef MUX_41_SEL_STATS_EN
    logic [31:0] a_sel_cnt, b_sel_cnt;
`endif

    mux_41 #(.WIDTH(1)) dut1 (
        .s0(a_s0), .s1(a_s1), .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
        .y(a_y), .clk(clk), .rst(a_rst), .y_q(a_y_q), .sel_chg(a_sel_chg)
`ifdef MUX_41_SEL_STATS_EN
        , .sel_cnt(a_sel_cnt)
`endif
    );

    mux_41 #(.WIDTH(8)) dut8 (
        .s0(b_s0), .s1(b_s1), .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
        .y(b_y), .clk(clk), .rst(b_rst), .y_q(b_y_q), .sel_chg(b_sel_chg)
`ifdef MUX_41_SEL_STATS_EN
        , .sel_cnt(b_sel_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [1:0] sel, input logic [3:0] d);
        a_s1 = sel[1];
        a_s0 = sel[0];
        {a_i3, a_i2, a_i1, a_i0} = d;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] d;      // {i3,i2,i1,i0}
        logic       y;
    } vec_t;

    vec_t vecs[4];

    // Behavioural model state for the random phase
    logic [7:0] d[4];
    int         m_prev_sel;
    bit         m_valid;
    int         m_cnt[4];
    logic [7:0] exp_yq;
    bit         exp_chg;

    initial begin
        vecs[0] = '{sel: 2'b00, d: 4'b1001, y: 1'b1};
        vecs[1] = '{sel: 2'b01, d: 4'b1001, y: 1'b0};
        vecs[2] = '{sel: 2'b10, d: 4'b1001, y: 1'b0};
        vecs[3] = '{sel: 2'b11, d: 4'b1001, y: 1'b1};

        // Directed combinational vectors, each checked 5 time units later
        for (int k = 0; k < 4; k++) begin
            set_a(vecs[k].sel, vecs[k].d);
            #5;
            check($sformatf("vec%0d_y", k), 32'(a_y), 32'(vecs[k].y));
        end

        // Exhaustive 2^6 over select and data
        for (int n = 0; n < 64; n++) begin
            logic [5:0] v;
            logic [3:0] dd;
            v  = n[5:0];
            dd = v[5:2];
            set_a(v[1:0], dd);
            #1;
            check($sformatf("exh%0d_y", n), 32'(a_y), 32'(dd[v[1:0]]));
        end

        // Reset state, then first capture of sel=11 with i3=1
        @(negedge clk);
        a_rst = 1;
        set_a(2'b00, 4'b0000);
        tick();
        check("rst_y_q", 32'(a_y_q), 32'd0);
        check("rst_sel_chg", 32'(a_sel_chg), 32'd0);
        a_rst = 0;
        set_a(2'b11, 4'b1000);
        tick();
        check("first_y_q", 32'(a_y_q), 32'd1);
        check("first_sel_chg", 32'(a_sel_chg), 32'd0);

        // Select sequence 00,00,01,01,10 after reset -> 0,0,1,0,1
        begin
            logic [1:0] seq[5];
            bit         chg[5];
            logic [3:0] dd;
            seq = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
            chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
            dd  = 4'b1001;
            a_rst = 1;
            tick();
            a_rst = 0;
            for (int k = 0; k < 5; k++) begin
                set_a(seq[k], dd);
                tick();
                check($sformatf("seq%0d_sel_chg", k), 32'(a_sel_chg), 32'(chg[k]));
                check($sformatf("seq%0d_y_q", k), 32'(a_y_q), 32'(dd[seq[k]]));
            end
        end

        // Reset while the select toggles; release with a select differing
        // from the reset value of the registered select.
        begin
            logic [3:0] dd;
            logic [1:0] s;
            dd = 4'b1010;
            a_rst = 1;
            for (int k = 0; k < 6; k++) begin
                s = (k % 2 == 0) ? 2'b11 : 2'b01;
                set_a(s, dd);
                #1;
                check($sformatf("mrst%0d_y", k), 32'(a_y), 32'(dd[s]));
                tick();
                check($sformatf("mrst%0d_y_q", k), 32'(a_y_q), 32'd0);
                check($sformatf("mrst%0d_sel_chg", k), 32'(a_sel_chg), 32'd0);
            end
            a_rst = 0;
            set_a(2'b01, dd);
            tick();
            check("release_sel_chg", 32'(a_sel_chg), 32'd0);
            check("release_y_q", 32'(a_y_q), 32'd1);
            set_a(2'b10, dd);
            tick();
            check("post_release_sel_chg", 32'(a_sel_chg), 32'd1);
            check("post_release_y_q", 32'(a_y_q), 32'd0);
            tick();
            check("hold_sel_chg", 32'(a_sel_chg), 32'd0);
        end

`ifdef MUX_41_SEL_STATS_EN
        // Saturating counters: hold sel=10 for 300 edges
        a_rst = 1;
        tick();
        check("cnt_rst", a_sel_cnt, 32'h0);
        a_rst = 0;
        set_a(2'b10, 4'b0000);
        for (int k = 0; k < 5; k++) tick();
        check("cnt_5", a_sel_cnt, 32'h0005_0000);
        for (int k = 0; k < 295; k++) tick();
        check("cnt_sat", a_sel_cnt, 32'h00FF_0000);
        a_rst = 1;
        tick();
        check("cnt_clear", a_sel_cnt, 32'h0);
        a_rst = 0;
`endif

        // Random traffic on the WIDTH=8 instance against the model
        m_prev_sel = 0;
        m_valid    = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        for (int n = 0; n < 400; n++) begin
            int  sel;
            bit  r;
            r   = (n == 0) || ($urandom_range(0, 9) == 0);
            sel = int'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            b_rst = r;
            b_s1  = sel[1];
            b_s0  = sel[0];
            b_i0  = d[0];
            b_i1  = d[1];
            b_i2  = d[2];
            b_i3  = d[3];
            #1;
            check($sformatf("rnd%0d_y", n), 32'(b_y), 32'(d[sel]));
            if (r) begin
                exp_yq     = 8'd0;
                exp_chg    = 0;
                m_prev_sel = 0;
                m_valid    = 0;
                for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            end else begin
                exp_yq     = d[sel];
                exp_chg    = m_valid && (sel != m_prev_sel);
                m_prev_sel = sel;
                m_valid    = 1;
                if (m_cnt[sel] < 255) m_cnt[sel]++;
            end
            tick();
            check($sformatf("rnd%0d_y_q", n), 32'(b_y_q), 32'(exp_yq));
            check($sformatf("rnd%0d_sel_chg", n), 32'(b_sel_chg), 32'(exp_chg));
`ifdef MUX_41_SEL_STATS_EN
            check($sformatf("rnd%0d_sel_cnt", n), b_sel_cnt,
                  {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
